// File: rtl/simon_axil_pkg.sv
// Shared definitions for the Simon AXI4-Lite register bank: register offsets,
// response codes, channel FSM states and CTRL/STATUS bit positions.
package simon_axil_pkg;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_KEY0   = 6'h08;
    localparam logic [5:0] OFF_KEY1   = 6'h0C;
    localparam logic [5:0] OFF_KEY2   = 6'h10;
    localparam logic [5:0] OFF_KEY3   = 6'h14;
    localparam logic [5:0] OFF_DIN0   = 6'h18;
    localparam logic [5:0] OFF_DIN1   = 6'h1C;
    localparam logic [5:0] OFF_DOUT0  = 6'h20;
    localparam logic [5:0] OFF_DOUT1  = 6'h24;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DECRYPT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_START_ERR = 2;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/simon_axil_rdmux.sv
// Combinational read decode: selects the register addressed by rd_off and
// flags unaligned or unmapped offsets as SLVERR with zero data.
module simon_axil_rdmux
    import simon_axil_pkg::*;
(
    input  logic [5:0]   rd_off,
    input  logic         ctrl_decrypt,
    input  logic         ctrl_irq_en,
    input  logic         st_busy,
    input  logic         st_done,
    input  logic         st_start_err,
    input  logic [127:0] key,
    input  logic [63:0]  din,
    input  logic [63:0]  dout,
    output logic [31:0]  rdata,
    output logic [1:0]   rresp
);

    always_comb begin
        rdata = '0;
        rresp = OKAY;
        if (rd_off[1:0] != 2'b00) begin
            rresp = SLVERR;
        end else begin
            case (rd_off)
                OFF_CTRL: begin
                    rdata[CTRL_DECRYPT] = ctrl_decrypt;
                    rdata[CTRL_IRQ_EN]  = ctrl_irq_en;
                end
                OFF_STATUS: begin
                    rdata[ST_BUSY]      = st_busy;
                    rdata[ST_DONE]      = st_done;
                    rdata[ST_START_ERR] = st_start_err;
                end
                OFF_KEY0:  rdata = key[31:0];
                OFF_KEY1:  rdata = key[63:32];
                OFF_KEY2:  rdata = key[95:64];
                OFF_KEY3:  rdata = key[127:96];
                OFF_DIN0:  rdata = din[31:0];
                OFF_DIN1:  rdata = din[63:32];
                OFF_DOUT0: rdata = dout[31:0];
                OFF_DOUT1: rdata = dout[63:32];
                default:   rresp = SLVERR;
            endcase
        end
    end

endmodule

// File: rtl/simon_axil_regs.sv
// AXI4-Lite register bank in front of the Simon cipher core.
// Define SIMON_AXIL_IRQ_EN to enable CTRL.irq_en and the registered irq output.
module simon_axil_regs
    import simon_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [127:0]          core_key,
    output logic [63:0]           core_din,
    output logic                  core_decrypt,
    output logic                  core_start,
    input  logic [63:0]           core_dout,
    input  logic                  core_done,
    output logic                  irq
);

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [5:0]       aw_addr_q, aw_addr_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [3:0][31:0] key_q, key_d;
    logic [1:0][31:0] din_q, din_d;
    logic [63:0]      dout_q, dout_d;
    logic             decrypt_q, decrypt_d, irq_en_q, irq_en_d;
    logic             busy_q, busy_d, done_q, done_d, start_err_q, start_err_d;
    logic             core_start_q, core_start_d, irq_q, irq_d;

    logic             aw_hs, w_hs, ar_hs, wr_fire, wr_ok, status_rd, start_req;
    logic [5:0]       wr_off;
    logic [31:0]      wr_data, mux_rdata;
    logic [3:0]       wr_strb;
    logic [1:0]       mux_rresp;
    logic             unused_addr;

    assign unused_addr = ^{awaddr[ADDR_WIDTH-1:6], araddr[ADDR_WIDTH-1:6]};

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign ar_hs   = arvalid & arready;
    // A channel handshaking this cycle counts as held, so the commit lands on
    // the edge of the later handshake and bvalid shows up the cycle after.
    assign wr_off  = aw_held_q ? aw_addr_q : awaddr[5:0];
    assign wr_data = w_held_q ? w_data_q : wdata;
    assign wr_strb = w_held_q ? w_strb_q : wstrb;
    assign wr_fire = (wr_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign status_rd = ar_hs & (araddr[5:0] == OFF_STATUS);

    always_comb begin
        wr_ok = 1'b0;
        if (wr_off[1:0] == 2'b00) begin
            case (wr_off)
                OFF_CTRL, OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3,
                OFF_DIN0, OFF_DIN1: wr_ok = 1'b1;
                default:            wr_ok = 1'b0;
            endcase
        end
    end

    // ---------------- write channel FSM ----------------
    always_ff @(posedge aclk) begin
        if (arst) wr_state_q <= W_IDLE;
        else      wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = awaddr[5:0];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (wr_fire) begin
                    wr_state_d = W_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_ok ? OKAY : SLVERR;
                end
            end
            W_RESP: if (bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (wr_state_q == W_IDLE) & ~aw_held_q;
        wready  = (wr_state_q == W_IDLE) & ~w_held_q;
        bvalid  = (wr_state_q == W_RESP);
        bresp   = bresp_q;
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge aclk) begin
        if (arst) rd_state_q <= R_IDLE;
        else      rd_state_q <= rd_state_d;
    end

    // Data is captured at AR acceptance, so it reflects register state before
    // any write or core_done landing on the same edge.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: if (arvalid) begin
                rd_state_d = R_DATA;
                rdata_d    = mux_rdata;
                rresp_d    = mux_rresp;
            end
            R_DATA: if (rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (rd_state_q == R_IDLE);
        rvalid  = (rd_state_q == R_DATA);
        rdata   = rdata_q;
        rresp   = rresp_q;
    end

    simon_axil_rdmux u_rdmux (
        .rd_off       (araddr[5:0]),
        .ctrl_decrypt (decrypt_q),
        .ctrl_irq_en  (irq_en_q),
        .st_busy      (busy_q),
        .st_done      (done_q),
        .st_start_err (start_err_q),
        .key          (key_q),
        .din          (din_q),
        .dout         (dout_q),
        .rdata        (mux_rdata),
        .rresp        (mux_rresp)
    );

    // ---------------- register bank ----------------
    always_comb begin
        key_d        = key_q;
        din_d        = din_q;
        dout_d       = dout_q;
        decrypt_d    = decrypt_q;
        irq_en_d     = irq_en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        start_err_d  = start_err_q;
        core_start_d = 1'b0;
        start_req    = 1'b0;
        if (wr_fire && wr_ok) begin
            case (wr_off)
                OFF_CTRL: if (wr_strb[0]) begin
                    decrypt_d = wr_data[CTRL_DECRYPT];
`ifdef SIMON_AXIL_IRQ_EN
                    irq_en_d  = wr_data[CTRL_IRQ_EN];
`endif
                    start_req = wr_data[CTRL_START];
                end
                OFF_KEY0: key_d[0] = apply_wstrb(key_q[0], wr_data, wr_strb);
                OFF_KEY1: key_d[1] = apply_wstrb(key_q[1], wr_data, wr_strb);
                OFF_KEY2: key_d[2] = apply_wstrb(key_q[2], wr_data, wr_strb);
                OFF_KEY3: key_d[3] = apply_wstrb(key_q[3], wr_data, wr_strb);
                OFF_DIN0: din_d[0] = apply_wstrb(din_q[0], wr_data, wr_strb);
                OFF_DIN1: din_d[1] = apply_wstrb(din_q[1], wr_data, wr_strb);
                default: ;
            endcase
        end
        // Ordering gives set-over-clear: read clears first, core_done sets after.
        if (status_rd) begin
            done_d      = 1'b0;
            start_err_d = 1'b0;
        end
        if (core_done) begin
            dout_d = core_dout;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (start_req) begin
            if (busy_q) begin
                start_err_d = 1'b1;
            end else begin
                core_start_d = 1'b1;
                busy_d       = 1'b1;
                done_d       = 1'b0;
            end
        end
`ifdef SIMON_AXIL_IRQ_EN
        irq_d = done_d & irq_en_d;
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bresp_q      <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            key_q        <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            decrypt_q    <= 1'b0;
            irq_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bresp_q      <= bresp_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            key_q        <= key_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
            decrypt_q    <= decrypt_d;
            irq_en_q     <= irq_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_err_q  <= start_err_d;
            core_start_q <= core_start_d;
            irq_q        <= irq_d;
        end
    end

    assign core_key     = key_q;
    assign core_din     = din_q;
    assign core_decrypt = decrypt_q;
    assign core_start   = core_start_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_simon_axil_regs.sv
// Randomised bench for simon_axil_regs against a transaction-level register model,
// with directed register-map, start/done, error, backpressure and reset cases.
module tb_simon_axil_regs;

`ifdef SIMON_AXIL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic         aclk = 1'b0, arst = 1'b1;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] core_key;
    logic [63:0]  core_din;
    logic         core_decrypt, core_start, irq;
    logic [63:0]  core_dout = '0;
    logic         core_done = 1'b0;

    simon_axil_regs #(.ADDR_WIDTH(32)) dut (
        .aclk(aclk), .arst(arst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .core_key(core_key), .core_din(core_din), .core_decrypt(core_decrypt),
        .core_start(core_start), .core_dout(core_dout), .core_done(core_done),
        .irq(irq)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0, cyc = 0, start_cycles = 0;
    always @(posedge aclk) cyc <= cyc + 1;
    always @(negedge aclk) if (core_start) start_cycles++;

    // ---------------- register model ----------------
    logic [31:0] m_key [4];
    logic [31:0] m_din [2];
    logic [63:0] m_dout;
    bit          m_dec, m_irq_en, m_busy, m_done, m_err, mon_en = 0;
    int          m_start_cyc = -1;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_din[0] = '0; m_din[1] = '0; m_dout = '0;
        m_dec = 0; m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_start_cyc = -1;
    endfunction

    function automatic logic [1:0] m_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int o = int'(off);
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (o % 4 != 0 || o == 4 || o > 28) return 2'b10;
        if (o == 0) begin
            if (s[0]) begin
                m_dec = d[1];
                if (IRQ) m_irq_en = d[2];
                if (d[0]) begin
                    if (m_busy) m_err = 1;
                    else begin m_busy = 1; m_done = 0; m_start_cyc = cyc; end
                end
            end
        end else if (o < 24) m_key[(o - 8) / 4] = (m_key[(o - 8) / 4] & ~mask) | (d & mask);
        else                 m_din[(o - 24) / 4] = (m_din[(o - 24) / 4] & ~mask) | (d & mask);
        return 2'b00;
    endfunction

    function automatic logic [33:0] m_read(input logic [5:0] off);
        int o = int'(off);
        if (o % 4 != 0) return {2'b10, 32'h0};
        case (o)
            0:              return {2'b00, 29'h0, m_irq_en, m_dec, 1'b0};
            4:              return {2'b00, 29'h0, m_err, m_done, m_busy};
            8, 12, 16, 20:  return {2'b00, m_key[(o - 8) / 4]};
            24, 28:         return {2'b00, m_din[(o - 24) / 4]};
            32:             return {2'b00, m_dout[31:0]};
            36:             return {2'b00, m_dout[63:32]};
            default:        return {2'b10, 32'h0};
        endcase
    endfunction

    function automatic void model_done(input logic [63:0] v);
        m_dout = v; m_busy = 0; m_done = 1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core-facing outputs compared to the model every cycle.
    always @(negedge aclk) if (mon_en) begin
        chk("core_key", core_key, {m_key[3], m_key[2], m_key[1], m_key[0]});
        chk("core_din", core_din, {64'h0, m_din[1], m_din[0]});
        chk("core_decrypt", core_decrypt, m_dec);
        chk("core_start", core_start, cyc == m_start_cyc);
        chk("irq", irq, IRQ & m_done & m_irq_en);
    end

    // ---------------- bus tasks (start and end at posedge+1) ----------------
    task automatic do_reset(input int n);
        mon_en = 0; arst = 1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; core_done = 0;
        repeat (n) @(posedge aclk);
        #1 arst = 0;
        model_reset();
        mon_en = 1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_dly, input int w_dly, input int b_hold, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        logic [1:0] er;
        resp = 2'bxx;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && n >= aw_dly; awaddr = addr;
            wvalid  = !w_done && n >= w_dly;   wdata = data; wstrb = strb;
            @(negedge aclk);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done = 1;
            @(posedge aclk); #1;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL wr_timeout: addr %0h not accepted in 50 cycles", addr);
                awvalid = 0; wvalid = 0;
                return;
            end
        end
        awvalid = 0; wvalid = 0;
        er = m_write(addr[5:0], data, strb);
        for (int i = 0; i < b_hold; i++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, er);
            chk("awready_blocked", awready, 0);
            @(posedge aclk); #1;
        end
        bready = 1;
        @(negedge aclk);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, er);
        resp = bresp;
        @(posedge aclk); #1;
        bready = 0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic rd(input logic [31:0] addr, input int r_hold, input bit dn, input logic [63:0] dval,
                      output logic [31:0] data, output logic [1:0] resp);
        logic [33:0] e;
        int n = 0;
        data = 'x; resp = 'x;
        arvalid = 1; araddr = addr;
        @(negedge aclk);
        while (!arready) begin
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL rd_timeout: addr %0h not accepted in 20 cycles", addr);
                arvalid = 0;
                return;
            end
            @(posedge aclk); #1; @(negedge aclk);
        end
        if (dn) begin core_done = 1; core_dout = dval; end
        e = m_read(addr[5:0]);
        @(posedge aclk); #1;
        arvalid = 0; core_done = 0;
        if (addr[5:0] == 6'h04) begin m_done = 0; m_err = 0; end
        if (dn) model_done(dval);
        for (int i = 0; i < r_hold; i++) begin
            @(negedge aclk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, e[31:0]);
            chk("rresp_hold", rresp, e[33:32]);
            chk("arready_blocked", arready, 0);
            @(posedge aclk); #1;
        end
        rready = 1;
        @(negedge aclk);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, e[31:0]);
        chk("rresp", rresp, e[33:32]);
        data = rdata; resp = rresp;
        @(posedge aclk); #1;
        rready = 0;
        chk("rvalid_drop", rvalid, 0);
    endtask

    task automatic pulse_done(input logic [63:0] v);
        core_done = 1; core_dout = v;
        @(posedge aclk); #1;
        core_done = 0;
        model_done(v);
    endtask

    function automatic logic [5:0] pick_off();
        int r = $urandom_range(0, 13);
        if (r < 12) return 6'(r * 4);
        return 6'($urandom());
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        do_reset(2);
        chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
        chk("rst_awready", awready, 1); chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1); chk("rst_core_start", core_start, 0);
        chk("rst_irq", irq, 0);         chk("rst_rdata", rdata, 0);
        for (int o = 0; o < 40; o += 4) begin
            rd(32'(o), 0, 0, 0, d, rs);
            chk("rst_reg", d, 0);
        end

        // KEY0 write with AW leading W by 3 cycles, then a byte-masked update
        wr(32'h08, 32'h03020100, 4'hF, 0, 3, 0, rs);
        chk("key0_bresp", rs, 2'b00);
        rd(32'h08, 0, 0, 0, d, rs);
        chk("key0_read", d, 32'h03020100);
        wr(32'h08, 32'h000000FF, 4'h1, 2, 0, 0, rs);
        rd(32'h08, 0, 0, 0, d, rs);
        chk("key0_strb", d, 32'h030201FF);

        // Start, start-while-busy, completion
        wr(32'h00, 32'h1, 4'hF, 0, 0, 0, rs);
        rd(32'h04, 0, 0, 0, d, rs);
        chk("status_busy", d, 32'h1);
        chk("start_one_cycle", start_cycles, 1);
        wr(32'h00, 32'h1, 4'hF, 0, 0, 0, rs);
        chk("busy_start_resp", rs, 2'b00);
        chk("busy_no_pulse", start_cycles, 1);
        pulse_done(64'h8C6FA548_454E028B);
        rd(32'h04, 0, 0, 0, d, rs);
        chk("status_done_err", d, 32'h6);
        rd(32'h04, 0, 0, 0, d, rs);
        chk("status_cleared", d, 32'h0);
        rd(32'h20, 0, 0, 0, d, rs);
        chk("dout0", d, 32'h454E028B);
        rd(32'h24, 0, 0, 0, d, rs);
        chk("dout1", d, 32'h8C6FA548);

        // Error responses
        rd(32'h28, 0, 0, 0, d, rs);
        chk("unmapped_resp", rs, 2'b10); chk("unmapped_data", d, 0);
        wr(32'h20, 32'hDEADBEEF, 4'hF, 0, 0, 0, rs);
        chk("ro_write_resp", rs, 2'b10);
        rd(32'h20, 0, 0, 0, d, rs);
        chk("ro_unchanged", d, 32'h454E028B);
        wr(32'h09, 32'hFFFFFFFF, 4'hF, 1, 0, 0, rs);
        chk("unaligned_resp", rs, 2'b10);
        rd(32'h08, 0, 0, 0, d, rs);
        chk("unaligned_no_write", d, 32'h030201FF);

        // Backpressure on both response channels
        wr(32'h18, 32'hA5A55A5A, 4'hF, 1, 0, 5, rs);
        rd(32'h18, 5, 0, 0, d, rs);
        chk("bp_read", d, 32'hA5A55A5A);

        // IRQ: enable, start, complete, clear via STATUS read
        wr(32'h00, 32'h4, 4'hF, 0, 0, 0, rs);
        rd(32'h00, 0, 0, 0, d, rs);
        chk("ctrl_irq_en", d, IRQ ? 32'h4 : 32'h0);
        wr(32'h00, 32'h7, 4'hF, 0, 0, 0, rs);
        pulse_done(64'h1122334455667788);
        chk("irq_set", irq, IRQ);
        rd(32'h04, 0, 0, 0, d, rs);
        chk("irq_status", d, 32'h2);
        chk("irq_clear", irq, 0);

        // core_done on the same edge as the STATUS read: read sees pre-set value
        wr(32'h00, 32'h1, 4'hF, 0, 0, 0, rs);
        rd(32'h04, 0, 1, 64'hCAFEF00D_0BADBEEF, d, rs);
        chk("done_vs_read_old", d, 32'h1);
        rd(32'h04, 0, 0, 0, d, rs);
        chk("done_vs_read_set", d, 32'h2);

        // Same-cycle write and read of KEY1 returns the old value
        wr(32'h0C, 32'h11111111, 4'hF, 0, 0, 0, rs);
        fork
            wr(32'h0C, 32'h22222222, 4'hF, 0, 0, 0, rs);
            begin
                logic [31:0] dd; logic [1:0] rr;
                rd(32'h0C, 0, 0, 0, dd, rr);
                chk("rw_same_cycle_old", dd, 32'h11111111);
            end
        join
        rd(32'h0C, 0, 0, 0, d, rs);
        chk("rw_same_cycle_new", d, 32'h22222222);

        // Reset with a half-received write and a pending read response
        awvalid = 1; awaddr = 32'h10;
        @(posedge aclk); #1 awvalid = 0;
        chk("aw_only_awready", awready, 0); chk("aw_only_wready", wready, 1);
        arvalid = 1; araddr = 32'h08;
        @(posedge aclk); #1 arvalid = 0;
        chk("pending_rvalid", rvalid, 1);
        do_reset(1);
        chk("mid_rst_bvalid", bvalid, 0); chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_awready", awready, 1); chk("mid_rst_wready", wready, 1);
        // W alone must wait for a fresh AW after reset
        wvalid = 1; wdata = 32'h5EED5EED; wstrb = 4'hF;
        @(posedge aclk); #1 wvalid = 0;
        repeat (2) @(posedge aclk);
        #1 chk("w_only_no_bvalid", bvalid, 0);
        awvalid = 1; awaddr = 32'h14;
        @(posedge aclk); #1 awvalid = 0;
        void'(m_write(6'h14, 32'h5EED5EED, 4'hF));
        chk("late_aw_bvalid", bvalid, 1); chk("late_aw_bresp", bresp, 2'b00);
        bready = 1;
        @(posedge aclk); #1 bready = 0;
        rd(32'h14, 0, 0, 0, d, rs);
        chk("late_aw_key3", d, 32'h5EED5EED);

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            logic [31:0] a, dr, got;
            logic [1:0]  r2;
            int kind;
            a = $urandom(); a[5:0] = pick_off();
            dr = $urandom();
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                if (a[5:0] == 6'h00 && $urandom_range(0, 2) != 0) dr[0] = 1'b0;
                wr(a, dr, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), r2);
            end else if (kind == 8 && m_busy) begin
                if ($urandom_range(0, 1) != 0) pulse_done({$urandom(), $urandom()});
                else rd(a, $urandom_range(0, 2), 1, {$urandom(), $urandom()}, got, r2);
            end else begin
                rd(a, $urandom_range(0, 2), 0, 0, got, r2);
            end
        end

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
